// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 request path: line-address width, trace command
// codes and the queued request record.
package l2_pkg;

  localparam int unsigned LINE_AW = 26;

  typedef enum logic [3:0] {
    CmdRead       = 4'd0,
    CmdWrite      = 4'd1,
    CmdInvalidate = 4'd3,
    CmdReset      = 4'd8,
    CmdPrint      = 4'd9
  } trace_cmd_e;

  typedef struct packed {
    logic [LINE_AW-1:0] addr;
    logic               write;
  } l2_req_t;

endpackage

// File: rtl/l2_match_cam.sv
// Combinational DEPTH-way line-address comparator; reports a hit and a one-hot hit index.
module l2_match_cam #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 26
) (
  input  logic [AW-1:0]    entry_addr [DEPTH],
  input  logic [DEPTH-1:0] occ,
  input  logic [AW-1:0]    in_addr,
  output logic             hit,
  output logic [DEPTH-1:0] hit_onehot
);

  // Callers keep occupied entries unique, so at most one bit can be set.
  always_comb begin
    hit_onehot = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      hit_onehot[i] = occ[i] && (entry_addr[i] == in_addr);
    end
  end

  assign hit = |hit_onehot;

endmodule

// File: rtl/l2_req_queue.sv
// Show-ahead FIFO of next-level line requests from the L1 cache, merging duplicate lines
// and keeping enqueue/coalesce/drop statistics.
module l2_req_queue import l2_pkg::*; #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = LINE_AW,
  parameter int unsigned PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [AW-1:0]   in_addr,
  input  logic            in_write,
  input  logic            clear,
  output logic            out_valid,
  output logic [AW-1:0]   out_addr,
  output logic            out_write,
  input  logic            out_ready,
  output logic [PTRW:0]   level,
  output logic [31:0]     enq_cnt,
  output logic [31:0]     coal_cnt,
  output logic [31:0]     drop_cnt
);

  localparam logic [PTRW:0] DepthL = (PTRW+1)'(DEPTH);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DEPTH-1:0] wflag_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTRW:0]    level_q, level_d;
  logic [31:0]      enq_q, coal_q, drop_q;

  logic             rst, pop, push, coal, drop, space, hit;
  logic [DEPTH-1:0] head_mask, occ, hit_onehot;

  assign rst       = reset | clear;
  assign out_valid = (level_q != '0);
  assign out_addr  = out_valid ? addr_q[rd_ptr_q] : '0;
  assign out_write = out_valid ? wflag_q[rd_ptr_q] : 1'b0;
  assign level     = level_q;
  assign enq_cnt   = enq_q;
  assign coal_cnt  = coal_q;
  assign drop_cnt  = drop_q;

  assign pop = out_valid & out_ready;

  // The departing head must not absorb a request, or it would be lost with the pop.
  assign head_mask = pop ? (DEPTH'(1) << rd_ptr_q) : '0;
  assign occ       = valid_q & ~head_mask;

  l2_match_cam #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_match_cam (
    .entry_addr (addr_q),
    .occ        (occ),
    .in_addr    (in_addr),
    .hit        (hit),
    .hit_onehot (hit_onehot)
  );

  assign space = (level_q < DepthL) | pop;
  assign coal  = in_valid & hit;
  assign push  = in_valid & ~hit & space;
  assign drop  = in_valid & ~hit & ~space;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTRW'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    // Applied after the pop so a full-queue push into the freed slot stays valid.
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTRW'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + (PTRW+1)'(1);
      2'b01:   level_d = level_q - (PTRW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= '0;
      enq_q    <= '0;
      coal_q   <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      if (push) enq_q  <= enq_q + 32'd1;
      if (coal) coal_q <= coal_q + 32'd1;
      if (drop) drop_q <= drop_q + 32'd1;
    end
  end

  // Payload needs no reset; it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q]  <= in_addr;
      wflag_q[wr_ptr_q] <= in_write;
    end
    if (coal && in_write) begin
      wflag_q <= wflag_q | hit_onehot;
    end
  end

endmodule
